// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
//   Sequences one 3x3 multiply-accumulate job. A job request latches a channel
//   count. One 9-lane operand pair is issued to an external multiplier and
//   adder tree per accepted input. The tree_sum values that come back are
//   accumulated, and the total is presented on a valid/ready output.
//
//   Build option: define MAC_SAT_EN to clamp every accumulation to the signed
//   ACC_W range. Without it the accumulator wraps modulo 2^ACC_W.
//
// Parameters
//   TREE_LAT  cycles from mul_md/mul_mr presentation to the matching tree_sum (>=1)
//   ACC_W     accumulator / result width
//   CH_W      channel count width
//
// Ports
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready  job request handshake, cfg_nch = number of windows
//   in_valid/in_ready    operand pair handshake, in_md/in_mr = 9 x s8, lane 0 in [71:64]
//   mul_md, mul_mr       registered operands to the multiplier (zero when idle)
//   tree_sum             signed sum of nine products, TREE_LAT cycles after issue
//   out_valid/out_ready  result handshake, out_data = signed accumulated result
//   busy                 high whenever a job is in progress
// -----------------------------------------------------------------------------
module mac_sequencer #(
   parameter int TREE_LAT = 2,
   parameter int ACC_W    = 32,
   parameter int CH_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_nch,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [71:0]      in_md,
   input  logic [71:0]      in_mr,
   output logic [71:0]      mul_md,
   output logic [71:0]      mul_mr,
   input  logic [19:0]      tree_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

`ifdef MAC_SAT_EN
   localparam int WIDE_W = ACC_W + 21;
   localparam logic signed [WIDE_W-1:0] SAT_MAX = {{22{1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] SAT_MIN = {{22{1'b1}}, {(ACC_W-1){1'b0}}};

   // Adds one tree sum to the accumulator and clamps to the signed ACC_W range.
   // The sum is formed wide enough that it can never overflow.
   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [19:0]      t);
      logic signed [WIDE_W-1:0] wide_v;
      wide_v = WIDE_W'($signed(a)) + WIDE_W'($signed(t));
      if (wide_v > SAT_MAX) begin
         return {1'b0, {(ACC_W-1){1'b1}}};
      end else if (wide_v < SAT_MIN) begin
         return {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         return wide_v[ACC_W-1:0];
      end
   endfunction
`else
   // Adds one sign-extended tree sum to the accumulator. The result wraps modulo 2^ACC_W.
   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [19:0]      t);
      return a + ACC_W'($signed(t));
   endfunction
`endif

   state_t               state_r, state_s;
   logic [CH_W-1:0]      nch_r, nch_s;
   logic [CH_W-1:0]      issued_r, issued_s;
   logic [CH_W-1:0]      done_r, done_s;
   logic [ACC_W-1:0]     acc_r, acc_s;
   // tag_r[i] marks an issue whose tree_sum arrives i+1 cycles after the
   // multiplier stage. The top bit lines up with tree_sum.
   logic [TREE_LAT-1:0]  tag_r, tag_s;
   logic                 mul_vld_r, mul_vld_s;
   logic [71:0]          mul_md_r, mul_md_s;
   logic [71:0]          mul_mr_r, mul_mr_s;
   logic                 cfg_ready_r, cfg_ready_s;
   logic                 in_ready_r, in_ready_s;
   logic                 out_valid_r, out_valid_s;
   logic                 busy_r, busy_s;
   logic [ACC_W-1:0]     out_data_r, out_data_s;

   assign cfg_ready = cfg_ready_r;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign out_data  = out_data_r;
   assign mul_md    = mul_md_r;
   assign mul_mr    = mul_mr_r;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_s   = state_r;
      nch_s     = nch_r;
      issued_s  = issued_r;
      mul_vld_s = 1'b0;
      mul_md_s  = 72'd0;
      mul_mr_s  = 72'd0;
      tag_s     = (tag_r << 1'b1) | TREE_LAT'(mul_vld_r);

      // A tree_sum only counts when a tag says it belongs to the current job.
      if (tag_r[TREE_LAT-1] && ((state_r == RUN) || (state_r == DRAIN))) begin
         acc_s  = acc_add(acc_r, tree_sum);
         done_s = done_r + CH_W'(1'b1);
      end else begin
         acc_s  = acc_r;
         done_s = done_r;
      end

      case (state_r)
         IDLE: begin
            if (cfg_valid) begin
               nch_s    = cfg_nch;
               issued_s = {CH_W{1'b0}};
               done_s   = {CH_W{1'b0}};
               acc_s    = {ACC_W{1'b0}};
               tag_s    = {TREE_LAT{1'b0}};
               if (cfg_nch != {CH_W{1'b0}}) begin
                  state_s = RUN;
               end else begin
                  state_s = OUT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (in_valid && in_ready_r) begin
               mul_vld_s = 1'b1;
               mul_md_s  = in_md;
               mul_mr_s  = in_mr;
               issued_s  = issued_r + CH_W'(1'b1);
               if (issued_s == nch_r) begin
                  state_s = DRAIN;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            if (tag_r[TREE_LAT-1] && (done_s == nch_r)) begin
               state_s = OUT;
            end else begin
               state_s = DRAIN;
            end
         end
         OUT: begin
            if (out_ready && out_valid_r) begin
               state_s = IDLE;
            end else begin
               state_s = OUT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      cfg_ready_s = (state_s == IDLE);
      in_ready_s  = (state_s == RUN) && (issued_s < nch_s);
      out_valid_s = (state_s == OUT);
      busy_s      = (state_s != IDLE);
      // Capture the total on entry to OUT. The accumulator is frozen there, so the value holds.
      if (state_s == OUT) begin
         out_data_s = acc_s;
      end else begin
         out_data_s = out_data_r;
      end
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         nch_r       <= {CH_W{1'b0}};
         issued_r    <= {CH_W{1'b0}};
         done_r      <= {CH_W{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         tag_r       <= {TREE_LAT{1'b0}};
         mul_vld_r   <= 1'b0;
         mul_md_r    <= 72'd0;
         mul_mr_r    <= 72'd0;
         cfg_ready_r <= 1'b1;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= {ACC_W{1'b0}};
      end else begin
         state_r     <= state_s;
         nch_r       <= nch_s;
         issued_r    <= issued_s;
         done_r      <= done_s;
         acc_r       <= acc_s;
         tag_r       <= tag_s;
         mul_vld_r   <= mul_vld_s;
         mul_md_r    <= mul_md_s;
         mul_mr_r    <= mul_mr_s;
         cfg_ready_r <= cfg_ready_s;
         in_ready_r  <= in_ready_s;
         out_valid_r <= out_valid_s;
         busy_r      <= busy_s;
         out_data_r  <= out_data_s;
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_sequencer
//   Directed bench with a scoreboard. The stimulus pushes each job's expected
//   result into a queue. The monitor pops an entry and compares it whenever a
//   result handshake occurs. The multiplier and adder tree are modelled as the
//   sum of nine products, delayed TREE_LAT cycles. When no operands were
//   issued, the model drives a junk value instead.
// -----------------------------------------------------------------------------
module tb_mac_sequencer;

   localparam int TL = 2;
   localparam int AW = 20;
   localparam int CW = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CW-1:0]        cfg_nch;
   logic                 in_valid;
   logic                 in_ready;
   logic [71:0]          in_md, in_mr;
   logic [71:0]          mul_md, mul_mr;
   logic [19:0]          tree_sum;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [AW-1:0] out_data;
   logic                 busy;

   int n_cmp = 0;
   int n_bad = 0;
   logic signed [AW-1:0] exp_q[$];

   localparam logic [71:0] ONES = {9{8'h01}};
   localparam logic [71:0] TWOS = {9{8'h02}};
   localparam logic [71:0] NEG  = {9{8'h80}};
   localparam logic [71:0] SEQ  = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
   localparam logic [71:0] MIN1 = {9{8'hFF}};
   localparam logic [71:0] P127 = {9{8'h7F}};

`ifdef MAC_SAT_EN
   localparam int SAT_EXP = 524287;
`else
   localparam int SAT_EXP = -458752;
`endif

   always #5 clk = ~clk;

   mac_sequencer #(.TREE_LAT(TL), .ACC_W(AW), .CH_W(CW)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_nch(cfg_nch),
      .in_valid(in_valid), .in_ready(in_ready), .in_md(in_md), .in_mr(in_mr),
      .mul_md(mul_md), .mul_mr(mul_mr), .tree_sum(tree_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   // Multiplier and adder tree model.
   function automatic logic signed [19:0] dot9(input logic [71:0] a, input logic [71:0] b);
      logic signed [19:0] s;
      s = 20'sd0;
      for (int i = 0; i < 9; i++) begin
         s = s + $signed(a[71-8*i -: 8]) * $signed(b[71-8*i -: 8]);
      end
      return s;
   endfunction

   logic signed [19:0] pipe_s [TL];
   bit                 pipe_v [TL];

   always @(posedge clk) begin
      pipe_s[0] <= dot9(mul_md, mul_mr);
      pipe_v[0] <= (mul_md != 72'd0) || (mul_mr != 72'd0);
      for (int i = 1; i < TL; i++) begin
         pipe_s[i] <= pipe_s[i-1];
         pipe_v[i] <= pipe_v[i-1];
      end
   end

   assign tree_sum = pipe_v[TL-1] ? pipe_s[TL-1] : 20'h5A5A5;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic check72(input string name, input logic [71:0] act, input logic [71:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: samples 1 time unit after the falling edge.
   always begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: unexpected result %0d, expected none", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   // The tasks below are entered at a falling edge and return at a falling edge.
   task automatic start_job(input int nch, input int expv);
      int w;
      w = 0;
      while (!cfg_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("cfg_ready_wait", cfg_ready, 1);
      exp_q.push_back(AW'(expv));
      cfg_nch   = CW'(nch);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send_pairs(input int n, input logic [71:0] md, input logic [71:0] mr,
                             output int cyc);
      int sent;
      sent  = 0;
      cyc   = 0;
      in_md = md;
      in_mr = mr;
      in_valid = 1'b1;
      while (sent < n && cyc < 100) begin
         if (in_ready) sent++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("issues_sent", sent, n);
   endtask

   task automatic wait_out(output int cyc, output int ir_hi);
      cyc   = 0;
      ir_hi = 0;
      while (!out_valid && cyc < 60) begin
         if (in_ready) ir_hi++;
         @(negedge clk);
         cyc++;
      end
      check("out_valid_seen", out_valid, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   int c, l, ir;

   // Directed stimulus.
   initial begin
      reset = 1'b1; cfg_valid = 1'b0; cfg_nch = '0; in_valid = 1'b0;
      in_md = '0; in_mr = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      do_reset();
      check("rst_cfg_ready", cfg_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check72("rst_mul_md", mul_md, 72'd0);

      // Single window 1*2*9 = 18, latency TL+2 after issue
      start_job(1, 18);
      send_pairs(1, ONES, TWOS, c);
      check72("mul_md_issue", mul_md, ONES);
      check72("mul_mr_issue", mul_mr, TWOS);
      check("busy_run", busy, 1);
      wait_out(l, ir);
      check("latency", l + 1, TL + 2);
      check72("mul_md_idle", mul_md, 72'd0);
      @(negedge clk);
      check("cfg_ready_after_out", cfg_ready, 1);

      // Three back-to-back windows of (-128)*(-128)*9
      start_job(3, 442368);
      send_pairs(3, NEG, NEG, c);
      check("back_to_back_cycles", c, 3);
      in_valid = 1'b1;
      wait_out(l, ir);
      check("in_ready_in_drain", ir, 0);
      in_valid = 1'b0;
      @(negedge clk);

      // Zero windows: result 0 immediately, in_valid ignored
      in_valid = 1'b1;
      start_job(0, 0);
      check("nch0_out_valid", out_valid, 1);
      check("nch0_in_ready", in_ready, 0);
      @(negedge clk);
      check("nch0_idle", cfg_ready, 1);
      in_valid = 1'b0;

      // Mixed signs: -45 + 127*(-128)*9 = -146349
      start_job(2, -146349);
      send_pairs(1, SEQ, MIN1, c);
      send_pairs(1, P127, NEG, c);
      wait_out(l, ir);
      @(negedge clk);

      // Output stall of five cycles
      out_ready = 1'b0;
      start_job(2, 36);
      send_pairs(2, ONES, TWOS, c);
      wait_out(l, ir);
      for (int i = 0; i < 5; i++) begin
         check("stall_data", out_data, 36);
         check("stall_cfg_ready", cfg_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_cfg_ready", cfg_ready, 1);
      check("stall_release_out_valid", out_valid, 0);

      // Reset during a job with tags in flight, then a clean job
      start_job(4, 0);
      send_pairs(2, NEG, NEG, c);
      do_reset();
      check("midrst_busy", busy, 0);
      check("midrst_cfg_ready", cfg_ready, 1);
      start_job(1, 18);
      send_pairs(1, ONES, TWOS, c);
      wait_out(l, ir);
      @(negedge clk);

      // Overflow: four windows of 147456 in a 20-bit accumulator
      start_job(4, SAT_EXP);
      send_pairs(4, NEG, NEG, c);
      wait_out(l, ir);
      @(negedge clk);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter TREE_LAT, default 2, cycles from mul_md/mul_mr presentation to matching tree_sum.
REQ-002 SHALL have parameter ACC_W, default 32, accumulator and result width.
REQ-003 SHALL have parameter CH_W, default 8, width of channel count.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  job request.
REQ-007 cfg_ready  output  1  job accepted when high with cfg_valid.
REQ-008 cfg_nch  input  CH_W  unsigned number of 3x3 windows (channels) to accumulate.
REQ-009 in_valid  input  1  operand pair available.
REQ-010 in_ready  output  1  operand pair consumed when high with in_valid.
REQ-011 in_md, in_mr  input  72 each  nine packed signed 8-bit operands, lane 0 in bits [71:64].
REQ-012 mul_md, mul_mr  output  72 each  registered operands to the 9-lane multiplier, same packing.
REQ-013 tree_sum  input  20  signed sum of the nine products from the adder tree.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  result consumed when high with out_valid.
REQ-016 out_data  output  ACC_W  signed accumulated result.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, OUT.
REQ-019 cfg_ready SHALL be high only in IDLE; on handshake, latch nch, clear accumulator and counters; go RUN if nch>0, else OUT with out_data=0.
REQ-020 in_ready SHALL be high only in RUN while issued count < nch.
REQ-021 On in handshake at edge k, mul_md/mul_mr SHALL hold the pair during cycle k+1; otherwise they SHALL be driven to all zeros.
REQ-022 A TREE_LAT-deep valid tag shift register SHALL mark issues; tree_sum SHALL be accumulated (sign-extended to ACC_W) at the edge ending cycle k+1+TREE_LAT.
REQ-023 When issued count reaches nch, RUN SHALL go to DRAIN; DRAIN SHALL go to OUT at the edge accumulating the nch-th tag.
REQ-024 In OUT, out_valid SHALL be high and out_data stable until out_ready; on handshake go IDLE.
REQ-025 tree_sum SHALL be ignored in cycles with no tag; in_valid SHALL be ignored outside RUN.
REQ-026 Back-to-back issues SHALL be accepted every cycle (throughput 1 window/cycle).
REQ-027 Without saturation, accumulation SHALL wrap modulo 2^ACC_W.

Reset
REQ-028 reset SHALL force IDLE; cfg_ready=1 next cycle; in_ready=0, out_valid=0, busy=0, out_data=0, mul_md=mul_mr=0, tags, counters and accumulator cleared.
REQ-029 reset mid-job SHALL discard all in-flight tags; tree_sum returning afterwards SHALL not affect any later job.

Configuration
REQ-030 Macro MAC_SAT_EN defined: each accumulation SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-031 Macro MAC_SAT_EN undefined: no clamp logic; wrap per REQ-027.

Verification (bench models tree_sum as sum of nine products delayed TREE_LAT)
REQ-032 nch=1, all in_md bytes 0x01, in_mr bytes 0x02 -> out_data=18, out_valid at cycle 1+TREE_LAT+1 after issue.
REQ-033 nch=3, all bytes 0x80 both operands, in_valid held -> three consecutive issues, out_data=442368.
REQ-034 nch=0 -> no in_ready, out_valid next cycle, out_data=0.
REQ-035 out_ready low 5 cycles in OUT -> out_data stable, cfg_ready=0; out_ready high -> IDLE, cfg_ready=1 next cycle.
REQ-036 nch=4, reset after 2 issues, then nch=1 with 0x01/0x02 -> out_data=18, no stale contribution.
REQ-037 ACC_W=20, nch=4, all bytes 0x80 -> MAC_SAT_EN: 524287; without: -458752.
